// File: rtl/ext_mem_port.sv
// Initiator for the external-memory word protocol: splits read/write bursts into
// single-word bus strobes and returns read data in order through a small credit-limited FIFO.
module ext_mem_port #(
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              request_extmem,
  output logic              write_extmem,
  output logic [ADDR_W-1:0] addr_extmem,
  output logic [DATA_W-1:0] w_data,
  input  logic              valid_extmem,
  input  logic [DATA_W-1:0] data_extmem,
  output logic              finish,
  output logic              err_unexp,
  output logic [63:0]       busy_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  i_q, i_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              req_q, req_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [63:0]       busy_q, busy_d;

  logic              push, pop, issue, wr_fire;
  logic [CNT_W:0]    credit_used;

  assign cmd_ready      = (state_q == IDLE);
  assign wr_ready       = (state_q == WR) && (i_q < len_q);
  assign rd_valid       = (count_q != '0);
  assign rd_data        = mem_q[rd_ptr_q];
  assign request_extmem = req_q;
  assign write_extmem   = write_q;
  assign addr_extmem    = addr_q;
  assign w_data         = w_data_q;
  assign finish         = (state_q == DONE);
  assign err_unexp      = err_q;
  assign busy_cnt       = busy_q;

  // A word popped this cycle frees its slot, so it may be re-credited immediately.
  assign push        = valid_extmem && (out_q != '0);
  assign pop         = rd_valid && rd_ready;
  assign credit_used = {1'b0, out_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
  assign issue       = (state_q == RD) && (i_q < len_q) && (credit_used < (CNT_W+1)'(DEPTH));
  assign wr_fire     = wr_valid && wr_ready;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    i_d      = i_q;
    addr_d   = addr_q;
    w_data_d = w_data_q;
    req_d    = 1'b0;
    write_d  = 1'b0;
    err_d    = err_q | (valid_extmem && (out_q == '0));
    busy_d   = (state_q != IDLE) ? busy_q + 64'd1 : busy_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          base_d = cmd_addr;
          len_d  = cmd_len;
          i_d    = '0;
          busy_d = '0;
          if (cmd_len == '0)  state_d = DONE;
          else if (cmd_write) state_d = WR;
          else                state_d = RD;
        end
      end
      RD: begin
        if (issue) begin
          req_d  = 1'b1;
          addr_d = base_q + ADDR_W'(i_q);
          i_d    = i_q + LEN_W'(1);
        end
        if ((i_q == len_q) && (out_q == '0) && (count_q == '0)) state_d = DONE;
      end
      WR: begin
        if (wr_fire) begin
          write_d  = 1'b1;
          addr_d   = base_q + ADDR_W'(i_q);
          w_data_d = wr_data;
          i_d      = i_q + LEN_W'(1);
        end
        if (i_q == len_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (issue && !push)      out_d = out_q + CNT_W'(1);
    else if (!issue && push) out_d = out_q - CNT_W'(1);
    if (push) begin
      mem_d[wr_ptr_q] = data_extmem;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      i_q      <= '0;
      addr_q   <= '0;
      w_data_q <= '0;
      req_q    <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= '0;
      out_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      i_q      <= i_d;
      addr_q   <= addr_d;
      w_data_q <= w_data_d;
      req_q    <= req_d;
      write_q  <= write_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_ext_mem_port.sv
// Directed and randomized bursts against ext_mem_port, with an in-order memory responder
// and a reference model built from plain address arithmetic and a word-pattern function.
module tb_ext_mem_port;

  localparam int DEPTH  = 4;
  localparam int LEN_W  = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              request_extmem;
  logic              write_extmem;
  logic [ADDR_W-1:0] addr_extmem;
  logic [DATA_W-1:0] w_data;
  logic              valid_extmem;
  logic [DATA_W-1:0] data_extmem = '0;
  logic              finish;
  logic              err_unexp;
  logic [63:0]       busy_cnt;

  logic resp_valid = 1'b0;
  logic inject_valid = 1'b0;
  logic rd_level = 1'b0;
  logic rd_rand_mode = 1'b0;
  logic rd_rand_bit = 1'b0;

  assign valid_extmem = resp_valid | inject_valid;
  assign rd_ready     = rd_rand_mode ? rd_rand_bit : rd_level;

  ext_mem_port #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .request_extmem(request_extmem), .write_extmem(write_extmem),
    .addr_extmem(addr_extmem), .w_data(w_data),
    .valid_extmem(valid_extmem), .data_extmem(data_extmem),
    .finish(finish), .err_unexp(err_unexp), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int unsigned tick = 0;
  int          latency = 2;
  int          check_count = 0;
  int          pass_count = 0;
  int          fail_count = 0;
  int          finish_count = 0;
  int          both_high = 0;
  int unsigned finish_tick = 0;
  int unsigned last_write_tick = 0;

  logic [31:0]  req_log[$];
  int unsigned  req_tick[$];
  logic [31:0]  wr_addr_log[$];
  logic [31:0]  wr_data_log[$];
  logic [31:0]  pop_log[$];
  int unsigned  pend_due[$];
  logic [31:0]  pend_addr[$];
  logic [31:0]  wdata_q[$];

  // Contents the external memory returns for any word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    #1;
    rd_rand_bit = 1'($urandom_range(0, 1));
  end

  // Bus monitor plus in-order responder; responses land at least one cycle after the request.
  always @(negedge clk) begin
    int unsigned due;
    if (request_extmem) begin
      req_log.push_back(addr_extmem);
      req_tick.push_back(tick);
      due = tick + latency;
      if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
      pend_due.push_back(due);
      pend_addr.push_back(addr_extmem);
    end
    if (write_extmem) begin
      wr_addr_log.push_back(addr_extmem);
      wr_data_log.push_back(w_data);
      last_write_tick = tick;
    end
    if (request_extmem && write_extmem) both_high++;
    if (finish) begin
      finish_count++;
      finish_tick = tick;
    end
    if (rd_valid && rd_ready) pop_log.push_back(rd_data);
    resp_valid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] <= tick) begin
      resp_valid  = 1'b1;
      data_extmem = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_tick.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    pop_log.delete();
    finish_count = 0;
  endtask

  task automatic apply_stimulus(input logic write, input logic [31:0] addr, input logic [15:0] len);
    @(posedge clk); #1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int budget);
    int n = 0;
    while (finish_count < 1 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_output({tag, "_finish_seen"}, 64'(finish_count >= 1), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic feed_writes(input int gap_at, input bit rand_gaps);
    int k = 0;
    int guard = 0;
    bit hs;
    int n = wdata_q.size();
    if (n == 0) return;
    wr_valid = 1'b1;
    wr_data  = wdata_q[0];
    while (k < n && guard < 400) begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) begin
        k++;
        wr_valid = 1'b0;
        if (k == gap_at) begin
          repeat (2) @(posedge clk);
          #1;
        end else if (rand_gaps && $urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
        if (k < n) begin
          wr_valid = 1'b1;
          wr_data  = wdata_q[k];
        end
      end
    end
    wr_valid = 1'b0;
    check_output("write_feed_complete", 64'(k), 64'(n));
  endtask

  task automatic verify_read(input string tag, input logic [31:0] base, input int len);
    logic [31:0] obs;
    check_output({tag, "_req_count"}, 64'(req_log.size()), 64'(len));
    check_output({tag, "_pop_count"}, 64'(pop_log.size()), 64'(len));
    check_output({tag, "_finish_once"}, 64'(finish_count), 64'd1);
    for (int k = 0; k < len; k++) begin
      obs = 'x;
      if (k < req_log.size()) obs = req_log[k];
      check_output({tag, "_req_addr"}, {32'h0, obs}, {32'h0, 32'(base + 32'(k))});
      obs = 'x;
      if (k < pop_log.size()) obs = pop_log[k];
      check_output({tag, "_rd_data"}, {32'h0, obs}, {32'h0, mem_word(32'(base + 32'(k)))});
    end
  endtask

  task automatic verify_write(input string tag, input logic [31:0] base);
    logic [31:0] obs;
    int n = wdata_q.size();
    check_output({tag, "_strobe_count"}, 64'(wr_addr_log.size()), 64'(n));
    check_output({tag, "_no_requests"}, 64'(req_log.size()), 64'd0);
    check_output({tag, "_finish_once"}, 64'(finish_count), 64'd1);
    for (int k = 0; k < n; k++) begin
      obs = 'x;
      if (k < wr_addr_log.size()) obs = wr_addr_log[k];
      check_output({tag, "_addr"}, {32'h0, obs}, {32'h0, 32'(base + 32'(k))});
      obs = 'x;
      if (k < wr_data_log.size()) obs = wr_data_log[k];
      check_output({tag, "_data"}, {32'h0, obs}, {32'h0, wdata_q[k]});
    end
    if (n > 0) check_output({tag, "_finish_after_last"}, 64'(finish_tick - last_write_tick), 64'd1);
  endtask

  initial begin
    int n;
    int cnt;
    int len;
    logic [31:0] base;
    bit is_write;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_request", 64'(request_extmem), 64'd0);
    check_output("rst_write", 64'(write_extmem), 64'd0);
    check_output("rst_addr", 64'(addr_extmem), 64'd0);
    check_output("rst_finish", 64'(finish), 64'd0);
    check_output("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_output("rst_busy", busy_cnt, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Streaming read
    clear_logs();
    latency  = 2;
    rd_level = 1'b1;
    apply_stimulus(1'b0, 32'h0020_0000, 16'd4);
    wait_finish("stream", 200);
    verify_read("stream", 32'h0020_0000, 4);
    if (req_tick.size() == 4)
      check_output("stream_back_to_back", 64'(req_tick[3] - req_tick[0]), 64'd3);
    else
      check_output("stream_tick_count", 64'(req_tick.size()), 64'd4);

    // Backpressure: the credit rule caps reads in flight at the FIFO depth
    clear_logs();
    rd_level = 1'b0;
    apply_stimulus(1'b0, 32'h0030_0000, 16'd8);
    repeat (20) @(posedge clk);
    #1;
    check_output("bp_capped_requests", 64'(req_log.size()), 64'(DEPTH));
    check_output("bp_rd_valid", 64'(rd_valid), 64'd1);
    check_output("bp_head_word", {32'h0, rd_data}, {32'h0, mem_word(32'h0030_0000)});
    rd_level = 1'b1;
    wait_finish("bp", 300);
    verify_read("bp", 32'h0030_0000, 8);

    // Write burst with a two-cycle stall after the first word
    clear_logs();
    wdata_q = '{32'h1111, 32'h2222, 32'h3333};
    apply_stimulus(1'b1, 32'h0040_0000, 16'd3);
    feed_writes(1, 1'b0);
    wait_finish("wr", 200);
    verify_write("wr", 32'h0040_0000);

    // Zero length
    clear_logs();
    apply_stimulus(1'b0, 32'h0050_0000, 16'd0);
    wait_finish("zero", 50);
    check_output("zero_no_requests", 64'(req_log.size()), 64'd0);
    check_output("zero_no_writes", 64'(wr_addr_log.size()), 64'd0);
    check_output("zero_finish_once", 64'(finish_count), 64'd1);
    check_output("zero_busy_cnt", busy_cnt, 64'd1);

    // Address wrap
    clear_logs();
    apply_stimulus(1'b0, 32'hFFFF_FFFE, 16'd3);
    wait_finish("wrap", 200);
    verify_read("wrap", 32'hFFFF_FFFE, 3);

    // Reset after two reads are on the bus; their late responses become unexpected
    clear_logs();
    latency = 3;
    apply_stimulus(1'b0, 32'h0060_0000, 16'd8);
    n = 0;
    cnt = 0;
    while (cnt < 2 && n < 50) begin
      @(negedge clk);
      if (request_extmem) cnt++;
      n++;
    end
    rst = 1'b0;
    #1;
    check_output("mid_rst_request", 64'(request_extmem), 64'd0);
    check_output("mid_rst_addr", 64'(addr_extmem), 64'd0);
    check_output("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    check_output("mid_rst_err", 64'(err_unexp), 64'd0);
    check_output("mid_rst_busy", busy_cnt, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_output("mid_rst_req_total", 64'(req_log.size()), 64'd2);
    check_output("mid_rst_err_late", 64'(err_unexp), 64'd1);
    check_output("mid_rst_fifo_empty", 64'(rd_valid), 64'd0);
    check_output("mid_rst_no_pops", 64'(pop_log.size()), 64'd0);
    clear_logs();
    latency = 2;
    apply_stimulus(1'b0, 32'h0070_0000, 16'd1);
    wait_finish("post_rst", 100);
    verify_read("post_rst", 32'h0070_0000, 1);

    // Unexpected response while idle
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("idle_err_cleared", 64'(err_unexp), 64'd0);
    @(negedge clk);
    inject_valid = 1'b1;
    @(negedge clk);
    inject_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("idle_unexp_fifo", 64'(rd_valid), 64'd0);
    check_output("idle_unexp_err", 64'(err_unexp), 64'd1);

    // Randomized bursts
    for (int r = 0; r < 12; r++) begin
      clear_logs();
      latency  = $urandom_range(1, 3);
      len      = $urandom_range(0, 9);
      base     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5)) : 32'($urandom);
      is_write = 1'($urandom_range(0, 1));
      if (is_write) begin
        wdata_q.delete();
        for (int k = 0; k < len; k++) wdata_q.push_back(32'($urandom));
        apply_stimulus(1'b1, base, 16'(len));
        feed_writes(-1, 1'b1);
        wait_finish("rand_wr", 500);
        verify_write("rand_wr", base);
      end else begin
        rd_rand_mode = 1'b1;
        apply_stimulus(1'b0, base, 16'(len));
        wait_finish("rand_rd", 1000);
        rd_rand_mode = 1'b0;
        verify_read("rand_rd", base, len);
      end
    end

    check_output("never_both_strobes", 64'(both_high), 64'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
